// File: rtl/pls_multichan_generator.sv
// Multi-channel fixed-point ramp generator. Channels are time-multiplexed onto one AXI-Stream output.
// Optional macro PLS_GEN_SATURATE_EN makes acc+STEP saturate instead of wrapping.
module pls_multichan_generator #(
    parameter int  DATA_SIZE = 32,
    parameter int  CHANNELS  = 4,
    parameter int  LEN_SIZE  = 16,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cfg_wr,
    input  logic [CH_W-1:0]      cfg_chan,
    input  logic [1:0]           cfg_addr,
    input  logic [DATA_SIZE-1:0] cfg_data,
    input  logic                 update,
    input  logic                 start,
    input  logic                 stop,
    output logic [DATA_SIZE-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [CH_W-1:0]      m_axis_tid,
    output logic                 m_axis_tlast,
    output logic                 busy,
    output logic                 upd_pending
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    logic [DATA_SIZE-1:0] sh_base_q  [CHANNELS];
    logic [DATA_SIZE-1:0] sh_base_d  [CHANNELS];
    logic [DATA_SIZE-1:0] sh_step_q  [CHANNELS];
    logic [DATA_SIZE-1:0] sh_step_d  [CHANNELS];
    logic [LEN_SIZE-1:0]  sh_len_q   [CHANNELS];
    logic [LEN_SIZE-1:0]  sh_len_d   [CHANNELS];
    logic [DATA_SIZE-1:0] act_base_q [CHANNELS];
    logic [DATA_SIZE-1:0] act_base_d [CHANNELS];
    logic [DATA_SIZE-1:0] act_step_q [CHANNELS];
    logic [DATA_SIZE-1:0] act_step_d [CHANNELS];
    logic [LEN_SIZE-1:0]  act_len_q  [CHANNELS];
    logic [LEN_SIZE-1:0]  act_len_d  [CHANNELS];
    logic [DATA_SIZE-1:0] acc_q      [CHANNELS];
    logic [DATA_SIZE-1:0] acc_d      [CHANNELS];
    logic [LEN_SIZE-1:0]  k_q        [CHANNELS];
    logic [LEN_SIZE-1:0]  k_d        [CHANNELS];

    state_t               state_q, state_d;
    logic [CH_W-1:0]      ptr_q, ptr_d;
    logic [DATA_SIZE-1:0] tdata_q, tdata_d;
    logic [CH_W-1:0]      tid_q, tid_d;
    logic                 tvalid_q, tvalid_d;
    logic                 tlast_q, tlast_d;
    logic                 upd_pending_q, upd_pending_d;

    logic                 hs;
    logic                 copy_en;
    logic                 cfg_ok;
    logic [LEN_SIZE-1:0]  len_m1;

    function automatic logic [DATA_SIZE-1:0] add_step(input logic [DATA_SIZE-1:0] a,
                                                      input logic [DATA_SIZE-1:0] b);
        logic [DATA_SIZE-1:0] s;
        s = a + b;
`ifdef PLS_GEN_SATURATE_EN
        if ((a[DATA_SIZE-1] == b[DATA_SIZE-1]) && (s[DATA_SIZE-1] != a[DATA_SIZE-1])) begin
            s = a[DATA_SIZE-1] ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
        end
`endif
        return s;
    endfunction

    assign hs      = tvalid_q && m_axis_tready;
    assign copy_en = upd_pending_q && ((state_q == S_IDLE) || (hs && tlast_q));
    assign cfg_ok  = cfg_wr && (cfg_addr != 2'd3) && (int'(cfg_chan) < CHANNELS);
    // LEN==0 behaves as LEN==1, so the wrap point is k==0 in both cases.
    assign len_m1  = (act_len_q[ptr_q] == '0) ? '0 : act_len_q[ptr_q] - 1'b1;

    always_comb begin
        sh_base_d     = sh_base_q;
        sh_step_d     = sh_step_q;
        sh_len_d      = sh_len_q;
        act_base_d    = act_base_q;
        act_step_d    = act_step_q;
        act_len_d     = act_len_q;
        acc_d         = acc_q;
        k_d           = k_q;
        state_d       = state_q;
        ptr_d         = ptr_q;
        tdata_d       = tdata_q;
        tid_d         = tid_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        upd_pending_d = update | (upd_pending_q & ~copy_en);

        if (cfg_ok) begin
            case (cfg_addr)
                2'd0:    sh_base_d[cfg_chan] = cfg_data;
                2'd1:    sh_step_d[cfg_chan] = cfg_data;
                2'd2:    sh_len_d[cfg_chan]  = cfg_data[LEN_SIZE-1:0];
                default: ;
            endcase
        end

        // The copy reads the shadow flops, so a write on the same edge stays in shadow.
        if (copy_en) begin
            act_base_d = sh_base_q;
            act_step_d = sh_step_q;
            act_len_d  = sh_len_q;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_d[i] = sh_base_q[i];
                k_d[i]   = '0;
            end
        end else if (hs) begin
            if (k_q[ptr_q] == len_m1) begin
                acc_d[ptr_q] = act_base_q[ptr_q];
                k_d[ptr_q]   = '0;
            end else begin
                acc_d[ptr_q] = add_step(acc_q[ptr_q], act_step_q[ptr_q]);
                k_d[ptr_q]   = k_q[ptr_q] + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_RUN;
                    ptr_d   = '0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        acc_d[i] = copy_en ? sh_base_q[i] : act_base_q[i];
                        k_d[i]   = '0;
                    end
                    tvalid_d = 1'b1;
                    tdata_d  = acc_d[0];
                    tid_d    = '0;
                    tlast_d  = (CHANNELS == 1);
                end
            end
            default: begin
                if (hs) begin
                    ptr_d   = tlast_q ? '0 : ptr_q + 1'b1;
                    tdata_d = acc_d[ptr_d];
                    tid_d   = ptr_d;
                    tlast_d = (ptr_d == LAST_CH);
                end
                // A stop seen on the closing handshake of a frame skips DRAIN.
                if (hs && tlast_q && ((state_q == S_DRAIN) || stop)) begin
                    state_d  = S_IDLE;
                    tvalid_d = 1'b0;
                end else if (stop && (state_q == S_RUN)) begin
                    state_d = S_DRAIN;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sh_base_q[i]  <= '0;
                sh_step_q[i]  <= '0;
                sh_len_q[i]   <= '0;
                act_base_q[i] <= '0;
                act_step_q[i] <= '0;
                act_len_q[i]  <= '0;
                acc_q[i]      <= '0;
                k_q[i]        <= '0;
            end
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            tdata_q       <= '0;
            tid_q         <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            upd_pending_q <= 1'b0;
        end else begin
            sh_base_q     <= sh_base_d;
            sh_step_q     <= sh_step_d;
            sh_len_q      <= sh_len_d;
            act_base_q    <= act_base_d;
            act_step_q    <= act_step_d;
            act_len_q     <= act_len_d;
            acc_q         <= acc_d;
            k_q           <= k_d;
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            tdata_q       <= tdata_d;
            tid_q         <= tid_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            upd_pending_q <= upd_pending_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tid    = tid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q != S_IDLE);
    assign upd_pending   = upd_pending_q;

endmodule

// File: tb/tb_pls_multichan_generator.sv
// Directed bench for pls_multichan_generator (4 channels, 32-bit samples): vector table plus
// hand-written sequences for update timing, stop/drain, LEN=0, overflow and async reset.
module tb_pls_multichan_generator;

    localparam int DW = 32;
    localparam int CH = 4;
    localparam int LW = 16;
    localparam int CW = 2;

`ifdef PLS_GEN_SATURATE_EN
    localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] SAT_EXP = 32'h8000_0010;
`endif

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          cfg_wr;
    logic [CW-1:0] cfg_chan;
    logic [1:0]    cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          update, start, stop;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready;
    logic [CW-1:0] m_axis_tid;
    logic          m_axis_tlast, busy, upd_pending;

    pls_multichan_generator #(.DATA_SIZE(DW), .CHANNELS(CH), .LEN_SIZE(LW)) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_wr(cfg_wr), .cfg_chan(cfg_chan),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .update(update), .start(start),
        .stop(stop), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tid(m_axis_tid),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .upd_pending(upd_pending)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        bit          rdy;
        int          tid;
        bit          last;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sample(input string tag, input int tid, input bit last, input logic [31:0] data);
        check({tag, "_tvalid"}, 32'(m_axis_tvalid), 32'd1);
        check({tag, "_tid"}, 32'(m_axis_tid), 32'(tid));
        check({tag, "_tlast"}, 32'(m_axis_tlast), 32'(last));
        check({tag, "_tdata"}, m_axis_tdata, data);
    endtask

    task automatic cfg(input int ch, input int addr, input logic [31:0] data);
        cfg_wr = 1'b1; cfg_chan = CW'(ch); cfg_addr = 2'(addr); cfg_data = data;
        @(negedge aclk);
        cfg_wr = 1'b0;
    endtask

    // Called at a negedge with tid 0 presented; runs one frame with tready=1.
    task automatic frame(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] d3, input int stop_idx);
        logic [31:0] d[4];
        d = '{d0, d1, d2, d3};
        for (int i = 0; i < 4; i++) begin
            sample($sformatf("frame_s%0d", i), i, i == 3, d[i]);
            check($sformatf("frame_busy%0d", i), 32'(busy), 32'd1);
            m_axis_tready = 1'b1;
            stop = (i == stop_idx);
            @(negedge aclk);
        end
        stop = 1'b0;
        $display("frame %h %h %h %h stop_idx=%0d", d0, d1, d2, d3, stop_idx);
    endtask

    task automatic update_then_start();
        update = 1'b1;
        @(negedge aclk);
        update = 1'b0; start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    initial begin
        int ch0_vals[6] = '{10, 15, 20, 10, 15, 20};
        vec_t v;

        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < 4; c++) begin
                v.tid = c; v.last = (c == 3); v.data = (c == 0) ? 32'(ch0_vals[f]) : 32'd0;
                if (f == 3 && c == 0) begin
                    v.rdy = 1'b0;
                    repeat (5) vecs.push_back(v);
                end
                v.rdy = 1'b1;
                vecs.push_back(v);
            end
        end

        aresetn = 1'b0; cfg_wr = 0; cfg_chan = 0; cfg_addr = 0; cfg_data = 0;
        update = 0; start = 0; stop = 0; m_axis_tready = 0;
        repeat (3) @(negedge aclk);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_tid", 32'(m_axis_tid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_upd", 32'(upd_pending), 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        cfg(0, 0, 32'd10); cfg(0, 1, 32'd5); cfg(0, 2, 32'd3);
        update = 1'b1;
        @(negedge aclk);
        update = 1'b0;
        check("upd_set", 32'(upd_pending), 32'd1);
        @(negedge aclk);
        check("upd_idle_copy", 32'(upd_pending), 32'd0);
        check("pre_start_tvalid", 32'(m_axis_tvalid), 32'd0);
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;

        foreach (vecs[i]) begin
            sample($sformatf("vec%0d", i), vecs[i].tid, vecs[i].last, vecs[i].data);
            $display("vec %0d rdy=%0d tid=%0d tdata=%h", i, vecs[i].rdy, m_axis_tid, m_axis_tdata);
            m_axis_tready = vecs[i].rdy;
            @(negedge aclk);
        end

        // Mid-frame update: old values finish the frame, copy lands on the tlast handshake.
        sample("mid_a", 0, 0, 32'd10);
        @(negedge aclk);
        sample("mid_b", 1, 0, 32'd0);
        cfg_wr = 1'b1; cfg_chan = 2'd1; cfg_addr = 2'd1; cfg_data = 32'd100; update = 1'b1;
        @(negedge aclk);
        sample("mid_c", 2, 0, 32'd0);
        check("mid_c_upd", 32'(upd_pending), 32'd1);
        cfg_addr = 2'd2; cfg_data = 32'd2; update = 1'b0;
        @(negedge aclk);
        cfg_wr = 1'b0;
        sample("mid_d", 3, 1, 32'd0);
        check("mid_d_upd", 32'(upd_pending), 32'd1);
        @(negedge aclk);
        check("mid_e_upd", 32'(upd_pending), 32'd0);
        frame(32'd10, 32'd0, 32'd0, 32'd0, -1);
        frame(32'd15, 32'd100, 32'd0, 32'd0, 1);
        check("drain_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);

        start = 1'b1; stop = 1'b1;
        @(negedge aclk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);
        check("startstop_tvalid", 32'(m_axis_tvalid), 32'd0);

        // LEN=0 on ch2; reserved-address write on ch3 must leave it untouched.
        cfg(2, 0, 32'd7); cfg(2, 1, 32'd3); cfg(2, 2, 32'd0); cfg(3, 3, 32'hDEAD_BEEF);
        update_then_start();
        frame(32'd10, 32'd0, 32'd7, 32'd0, -1);
        frame(32'd15, 32'd100, 32'd7, 32'd0, -1);
        frame(32'd20, 32'd0, 32'd7, 32'd0, -1);
        frame(32'd10, 32'd100, 32'd7, 32'd0, 0);
        check("len0_idle", 32'(m_axis_tvalid), 32'd0);

        cfg(3, 0, 32'h7FFF_FFF0); cfg(3, 1, 32'h20); cfg(3, 2, 32'd2);
        update_then_start();
        frame(32'd10, 32'd0, 32'd7, 32'h7FFF_FFF0, -1);
        frame(32'd15, 32'd100, 32'd7, SAT_EXP, -1);

        // Async reset while stalled with an update pending.
        m_axis_tready = 1'b0; update = 1'b1;
        @(negedge aclk);
        update = 1'b0;
        sample("stall_pre_rst", 0, 0, 32'd20);
        check("stall_pre_rst_upd", 32'(upd_pending), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        check("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("arst_tdata", m_axis_tdata, 32'd0);
        check("arst_tid", 32'(m_axis_tid), 32'd0);
        check("arst_tlast", 32'(m_axis_tlast), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_upd", 32'(upd_pending), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        update_then_start();
        frame(32'd0, 32'd0, 32'd0, 32'd0, 0);
        check("post_rst_idle", 32'(m_axis_tvalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
